// File: rtl/led_matrix_scan_ctrl.sv
// led_matrix_scan_ctrl
//
// Avalon-MM slave that scans a COLS x ROWS LED matrix one column at a time
// out of a double-buffered frame store. Software fills the back buffer and
// requests a swap. The swap is committed only at a frame wrap, or at once
// while the scanner is idle, so a frame on the pins is never torn.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   address      register word address (0..COLS-1 COLn, 5 CTRL, 6 DIV, 7 STATUS)
//   chipselect   slave select
//   write_n      active-low write strobe
//   writedata    write data
//   readdata     combinational read data; unused bits read as 0
//   columns_out  one-hot active-high column enable
//   rows_out     active-high row data for the active column
//   frame_tick   one-cycle pulse in the first cycle of each new frame
//
// Build option:
//   LED_SCAN_BLANK_EN  when defined, 2 all-off cycles are inserted between
//                      columns to suppress ghosting (BLANK state).
module led_matrix_scan_ctrl #(
  parameter int COLS      = 5,
  parameter int ROWS      = 7,
  parameter int DIV_RESET = 50000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      address,
  input  logic            chipselect,
  input  logic            write_n,
  input  logic [31:0]     writedata,
  output logic [31:0]     readdata,
  output logic [COLS-1:0] columns_out,
  output logic [ROWS-1:0] rows_out,
  output logic            frame_tick
);

  // Column registers occupy addresses 0..4 at most; CTRL starts at 5.
  localparam int              NCOLREG  = (COLS < 5) ? COLS : 5;
  localparam logic [15:0]     DIV_INIT = 16'(DIV_RESET);
  localparam logic [3:0]      LAST_COL = 4'(COLS - 1);
  localparam logic [COLS-1:0] ONE_HOT0 = {{(COLS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1
`ifdef LED_SCAN_BLANK_EN
    , BLANK = 2'd2
`endif
  } state_t;

  state_t                     state_r;
  state_t                     state_nxt_s;
  logic [3:0]                 col_r;
  logic [3:0]                 col_nxt_s;
  logic [15:0]                rem_r;
  logic [15:0]                rem_nxt_s;
`ifdef LED_SCAN_BLANK_EN
  logic                       blank_r;
  logic                       blank_nxt_s;
`endif
  logic                       enable_r;
  logic                       enable_nxt_s;
  logic                       swap_r;
  logic                       swap_nxt_s;
  logic [15:0]                div_r;
  logic [7:0]                 frame_r;
  logic [COLS-1:0][ROWS-1:0]  back_r;
  logic [COLS-1:0][ROWS-1:0]  front_r;
  logic [COLS-1:0][ROWS-1:0]  front_nxt_s;
  logic [15:0][ROWS-1:0]      front_pad_s;
  logic [7:0][ROWS-1:0]       back_pad_s;
  logic                       wr_s;
  logic                       ctrl_wr_s;
  logic [15:0]                dwell_last_s;
  logic                       advance_s;
  logic                       wrap_s;
  logic                       commit_s;
  logic [COLS-1:0]            columns_nxt_s;
  logic [ROWS-1:0]            rows_nxt_s;
  logic                       unused_s;

  assign wr_s      = chipselect & ~write_n;
  assign ctrl_wr_s = wr_s & (address == 3'd5);

  // The FSM reacts to an enable write on the same edge that stores it, so
  // SCAN col 0 (or IDLE) is already in place in the cycle after the write.
  assign enable_nxt_s = ctrl_wr_s ? writedata[0] : enable_r;

  // A DIV of 0 behaves as 1; the counter holds cycles remaining after this one.
  assign dwell_last_s = (div_r == 16'd0) ? 16'd0 : (div_r - 16'd1);

  // While idle a pending swap lands on the very next edge so software can
  // preload a frame before enabling; otherwise only on the frame wrap.
  assign commit_s    = swap_r & ((state_r == IDLE) | wrap_s);
  assign front_nxt_s = commit_s ? back_r : front_r;

  // Padded views make the column / address selects exactly index-width sized.
  for (genvar g = 0; g < 16; g++) begin : g_front_pad
    if (g < COLS) begin : g_used
      assign front_pad_s[g] = front_nxt_s[g];
    end else begin : g_zero
      assign front_pad_s[g] = {ROWS{1'b0}};
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_back_pad
    if (g < NCOLREG) begin : g_used
      assign back_pad_s[g] = back_r[g];
    end else begin : g_zero
      assign back_pad_s[g] = {ROWS{1'b0}};
    end
  end

  assign unused_s = ^writedata[31:16];

  // Next-state logic for the scan FSM, including column advance and wrap.
  always_comb begin
    state_nxt_s = state_r;
    col_nxt_s   = col_r;
    rem_nxt_s   = rem_r;
    advance_s   = 1'b0;
    wrap_s      = 1'b0;
`ifdef LED_SCAN_BLANK_EN
    blank_nxt_s = blank_r;
`endif
    if (!enable_nxt_s) begin
      state_nxt_s = IDLE;
      col_nxt_s   = 4'd0;
      rem_nxt_s   = 16'd0;
`ifdef LED_SCAN_BLANK_EN
      blank_nxt_s = 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt_s = SCAN;
          col_nxt_s   = 4'd0;
          rem_nxt_s   = dwell_last_s;
        end
        SCAN: begin
          if (rem_r == 16'd0) begin
`ifdef LED_SCAN_BLANK_EN
            state_nxt_s = BLANK;
            blank_nxt_s = 1'b0;
`else
            advance_s   = 1'b1;
`endif
          end else begin
            rem_nxt_s = rem_r - 16'd1;
          end
        end
`ifdef LED_SCAN_BLANK_EN
        BLANK: begin
          if (blank_r) begin
            advance_s = 1'b1;
          end else begin
            blank_nxt_s = 1'b1;
          end
        end
`endif
        default: begin
          state_nxt_s = IDLE;
          col_nxt_s   = 4'd0;
          rem_nxt_s   = 16'd0;
        end
      endcase

      // DIV is sampled here, at the start of each column's dwell.
      if (advance_s) begin
        state_nxt_s = SCAN;
        rem_nxt_s   = dwell_last_s;
        if (col_r == LAST_COL) begin
          col_nxt_s = 4'd0;
          wrap_s    = 1'b1;
        end else begin
          col_nxt_s = col_r + 4'd1;
        end
      end else begin
        wrap_s = 1'b0;
      end
    end
  end

  // Swap request: a CTRL write of bit1 wins over a commit on the same edge.
  always_comb begin
    swap_nxt_s = swap_r;
    if (ctrl_wr_s && writedata[1]) begin
      swap_nxt_s = 1'b1;
    end else if (commit_s) begin
      swap_nxt_s = 1'b0;
    end else begin
      swap_nxt_s = swap_r;
    end
  end

  // Pin values for the next cycle, decoded from the next FSM state.
  always_comb begin
    columns_nxt_s = {COLS{1'b0}};
    rows_nxt_s    = {ROWS{1'b0}};
    if (state_nxt_s == SCAN) begin
      columns_nxt_s = ONE_HOT0 << col_nxt_s;
      rows_nxt_s    = front_pad_s[col_nxt_s];
    end else begin
      columns_nxt_s = {COLS{1'b0}};
      rows_nxt_s    = {ROWS{1'b0}};
    end
  end

  // Register read mux; no read latency.
  always_comb begin
    readdata = 32'd0;
    case (address)
      3'd5:    readdata = {30'd0, swap_r, enable_r};
      3'd6:    readdata = {16'd0, div_r};
      3'd7:    readdata = {16'd0, frame_r, col_r, 3'd0, swap_r};
      default: readdata = {{(32-ROWS){1'b0}}, back_pad_s[address]};
    endcase
  end

  // Scan FSM state, column index and dwell/blank counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      col_r   <= 4'd0;
      rem_r   <= 16'd0;
`ifdef LED_SCAN_BLANK_EN
      blank_r <= 1'b0;
`endif
    end else begin
      state_r <= state_nxt_s;
      col_r   <= col_nxt_s;
      rem_r   <= rem_nxt_s;
`ifdef LED_SCAN_BLANK_EN
      blank_r <= blank_nxt_s;
`endif
    end
  end

  // Control registers: enable, swap request, dwell divider, frame counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable_r <= 1'b0;
      swap_r   <= 1'b0;
      div_r    <= DIV_INIT;
      frame_r  <= 8'd0;
    end else begin
      enable_r <= enable_nxt_s;
      swap_r   <= swap_nxt_s;
      if (wr_s && (address == 3'd6)) begin
        div_r <= writedata[15:0];
      end
      if (wrap_s) begin
        frame_r <= frame_r + 8'd1;
      end
    end
  end

  // Frame store: front takes the pre-write back value on a commit edge,
  // while a simultaneous COLn write lands in back.
  always_ff @(posedge clk) begin
    if (reset) begin
      back_r  <= {(COLS*ROWS){1'b0}};
      front_r <= {(COLS*ROWS){1'b0}};
    end else begin
      front_r <= front_nxt_s;
      for (int i = 0; i < NCOLREG; i++) begin
        if (wr_s && (address == 3'(i))) begin
          back_r[i] <= writedata[ROWS-1:0];
        end
      end
    end
  end

  // Registered pin drivers.
  always_ff @(posedge clk) begin
    if (reset) begin
      columns_out <= {COLS{1'b0}};
      rows_out    <= {ROWS{1'b0}};
      frame_tick  <= 1'b0;
    end else begin
      columns_out <= columns_nxt_s;
      rows_out    <= rows_nxt_s;
      frame_tick  <= wrap_s;
    end
  end

endmodule
